// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer.
// Provides the FSM state encoding, the NOP instruction word,
// instruction field positions and the HALT opcode value.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXECUTE,
        S_HALTED
    } state_t;

    localparam logic [8:0] NOP_INSTR   = 9'h1E0;
    localparam logic [3:0] HALT_OPCODE = 4'd1;

    localparam int OPC_HI = 8;
    localparam int OPC_LO = 5;
    localparam int WRR_HI = 4;
    localparam int WRR_LO = 2;
    localparam int IMM_HI = 4;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: combinational next-PC computation.
// Ports:
//   pc           current program counter
//   imm          5-bit signed branch offset
//   branch_taken add sign-extended imm on top of the +1 step
//   restart      force next PC to 0
//   pc_next      next program counter (modulo 2^PC_W)
module fetch_pc_unit #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [4:0]      imm,
    input  logic            branch_taken,
    input  logic            restart,
    output logic [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] offset;

    always_comb begin
        offset  = branch_taken ? {{(PC_W-5){imm[4]}}, imm} : '0;
        pc_next = restart ? '0 : pc + PC_W'(1) + offset;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-issue instruction fetch/issue sequencer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begins execution from IDLE, restarts from HALTED
//   imem_req/addr     instruction read request and address (= pc)
//   imem_ack/data     read completion and instruction word
//   opcode/wr_reg/imm instruction fields held in IR, to decoder
//   instr_valid       one-cycle pulse when a new instruction is presented
//   halt              decoder HALT, sampled only with exec_done
//   branch_taken      ALU branch decision, valid with exec_done
//   exec_done         datapath finished current instruction
//   pc                current program counter
//   halted            high while in HALTED
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         opcode,
    output logic [2:0]         wr_reg,
    output logic [4:0]         imm,
    output logic               instr_valid,
    input  logic               halt,
    input  logic               branch_taken,
    input  logic               exec_done,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    state_t              state, state_n;
    logic [INSTR_W-1:0]  ir;
    logic [PC_W-1:0]     pc_next;
    logic                pc_load;
    logic                restart;

    assign restart = (state == S_HALTED) && start;

    // PC only moves on a non-halting completion or a restart from HALTED.
    assign pc_load = restart || ((state == S_EXECUTE) && exec_done && !halt);

    fetch_pc_unit #(.PC_W(PC_W)) u_pc_unit (
        .pc           (pc),
        .imm          (imm),
        .branch_taken (branch_taken),
        .restart      (restart),
        .pc_next      (pc_next)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    state_n = start ? S_FETCH : S_IDLE;
            S_FETCH:   state_n = imem_ack ? S_ISSUE : S_FETCH;
            S_ISSUE:   state_n = S_EXECUTE;
            S_EXECUTE: state_n = !exec_done ? S_EXECUTE : (halt ? S_HALTED : S_FETCH);
            S_HALTED:  state_n = start ? S_FETCH : S_HALTED;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= INSTR_W'(NOP_INSTR);
        end else begin
            state <= state_n;
            if (state == S_FETCH && imem_ack)
                ir <= imem_data;
            else if (restart)
                ir <= INSTR_W'(NOP_INSTR);
            if (pc_load)
                pc <= pc_next;
        end
    end

    // All outputs decode from state or IR only; no input-to-output paths.
    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALTED);
    assign opcode      = ir[OPC_HI:OPC_LO];
    assign wr_reg      = ir[WRR_HI:WRR_LO];
    assign imm         = ir[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic       clk = 0;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [8:0] imem_data;
    logic [3:0] opcode;
    logic [2:0] wr_reg;
    logic [4:0] imm;
    logic       instr_valid;
    logic       halt;
    logic       branch_taken;
    logic       exec_done;
    logic [7:0] pc;
    logic       halted;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int vcyc  = 0;
    int t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decoder model: HALT is combinational on the presented opcode.
    assign halt = (opcode == 4'd1);

    fetch_sequencer #(.PC_W(8), .INSTR_W(9)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .opcode       (opcode),
        .wr_reg       (wr_reg),
        .imm          (imm),
        .instr_valid  (instr_valid),
        .halt         (halt),
        .branch_taken (branch_taken),
        .exec_done    (exec_done),
        .pc           (pc),
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in a FETCH cycle; leaves one cycle after the EXEC_DONE edge.
    task automatic run_instr(input logic [7:0] a, input logic [8:0] d, input int w, input logic br);
        logic [3:0] op0;
        op0 = opcode;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, a);
        for (int i = 0; i < w; i++) begin
            tick();
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, a);
            chk("opc_hold", opcode, op0);
            chk("no_valid_wait", instr_valid, 0);
        end
        imem_ack  = 1;
        imem_data = d;
        tick();
        imem_ack  = 0;
        vcyc      = cyc;
        chk("issue_valid", instr_valid, 1);
        chk("issue_opcode", opcode, d[8:5]);
        chk("issue_wr_reg", wr_reg, d[4:2]);
        chk("issue_imm", imm, d[4:0]);
        chk("issue_req_low", imem_req, 0);
        exec_done    = 1;
        branch_taken = br;
        tick();
        chk("valid_one_cycle", instr_valid, 0);
        chk("exec_opc_stable", opcode, d[8:5]);
        tick();
        exec_done    = 0;
        branch_taken = 0;
    endtask

    initial begin
        rst_n = 0; start = 0; imem_ack = 0; imem_data = '0;
        branch_taken = 0; exec_done = 0;
        repeat (2) tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_opcode", opcode, 4'hF);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_imm", imm, 0);
        rst_n = 1;
        tick();
        chk("idle_req", imem_req, 0);

        // Straight-line program 0..2, halting on opcode 1.
        start = 1;
        tick();
        start = 0;
        run_instr(8'd0, 9'h040, 0, 0);
        t0 = vcyc;
        run_instr(8'd1, 9'h060, 0, 0);
        chk("issue_rate", vcyc - t0, 3);
        t0 = vcyc;
        run_instr(8'd2, 9'h020, 0, 0);
        chk("issue_rate2", vcyc - t0, 3);
        chk("halted", halted, 1);
        chk("halt_pc", pc, 2);
        chk("halt_req", imem_req, 0);
        tick();
        chk("halt_stays", halted, 1);

        // Restart from HALTED.
        start = 1;
        tick();
        start = 0;
        chk("restart_pc", pc, 0);
        chk("restart_req", imem_req, 1);
        chk("restart_halted", halted, 0);
        chk("restart_opcode", opcode, 4'hF);

        run_instr(8'd0, 9'h044, 0, 1);
        chk("br_to_5", pc, 5);
        run_instr(8'd5, 9'h064, 4, 1);
        chk("br_to_10", pc, 10);
        run_instr(8'd10, 9'h05C, 0, 1);
        chk("br_neg4", imem_addr, 7);
        run_instr(8'd7, 9'h050, 0, 1);
        chk("br_neg_wrap", pc, 248);
        start = 1;
        run_instr(8'd248, 9'h040, 0, 0);
        start = 0;
        chk("start_ignored_pc", pc, 249);
        chk("start_ignored_req", imem_req, 1);
        run_instr(8'd249, 9'h040, 0, 0);
        chk("seq_250", pc, 250);
        run_instr(8'd250, 9'h04F, 0, 1);
        chk("br_pos_wrap", imem_addr, 10);
        run_instr(8'd10, 9'h054, 0, 1);
        chk("br_to_255", pc, 255);
        run_instr(8'd255, 9'h040, 0, 0);
        chk("pc_wrap", imem_addr, 0);
        chk("pc_wrap_req", imem_req, 1);

        // Reset mid-FETCH, then a late ACK.
        rst_n = 0;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_opcode", opcode, 4'hF);
        chk("async_pc", pc, 0);
        #2;
        rst_n     = 1;
        imem_ack  = 1;
        imem_data = 9'h040;
        tick();
        imem_ack  = 0;
        chk("late_ack_valid", instr_valid, 0);
        chk("late_ack_req", imem_req, 0);
        chk("late_ack_opcode", opcode, 4'hF);
        tick();
        chk("late_ack_valid2", instr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
